time_nmr_end: RTL and testbench
===============================

Name: time_nmr_end

Overview:
Parametrised N-modular successor to the time-redundant TMR end stage. It collects Redundancy time-repeated copies of each result, tagged by ID, from an arbitrated multi-opgroup pipeline. It majority-votes the copies word-wise and emits one result per group. While a group is partially collected it holds a lock to the upstream round-robin arbiter, with a timeout release. It sits between the rr_arb_tree_lock output and the downstream consumer.

Parameters:
DataWidth, 8, width of the payload word.
IDSize, 5, width of the group ID tag.
Redundancy, 3, number of copies per group; odd, 3..7.
LockTimeout, 5, cycles without an accepted copy before lock_o is released; 0 means lock_o is never timed out.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  1 = redundancy mode, 0 = bypass
data_i  in  DataWidth  incoming copy payload
id_i  in  IDSize  incoming copy group ID
valid_i  in  1  upstream valid
ready_o  out  1  upstream ready
data_o  out  DataWidth  voted result
valid_o  out  1  downstream valid
ready_i  in  1  downstream ready
lock_o  out  1  hold the upstream arbiter on its current input
fault_detected_o  out  1  one-cycle pulse on any detected discrepancy

Behaviour:
- Reset state: valid_o=0, data_o=0, lock_o=0, fault_detected_o=0, FSM=COLLECT, cnt=0, all slots=0, last_id=all-ones. Reset asserted mid-group discards that group.
- enable_i is sampled only when FSM=COLLECT and cnt=0.
  - Bypass (enable_i=0): data_o=data_i, valid_o=valid_i, ready_o=ready_i, all combinational; lock_o=0; no fault pulses.
- Redundancy mode FSM has two states, COLLECT and OUTPUT.
- COLLECT:
  - ready_o=1.
  - Accept, cnt=0, id_i==last_id: stale or extra copy. Drop it and pulse fault.
  - Accept, cnt=0, otherwise: cur_id<=id_i, slot[0]<=data_i, cnt<=1, lock_o<=1.
  - Accept, cnt>0, id_i==cur_id: slot[cnt]<=data_i, cnt<=cnt+1.
  - Accept, cnt>0, id_i!=cur_id: pulse fault, discard the partial group, restart with slot[0]<=data_i, cur_id<=id_i, cnt<=1.
  - When the accept makes cnt==Redundancy: go to OUTPUT next cycle and register the vote into data_o. valid_o=1 on the cycle after the last copy is accepted (latency 1).
- Vote:
  - Result is the word held by at least Redundancy/2+1 slots; the lowest-index matching slot wins.
  - If no word reaches majority, the result is the bitwise majority of all slots.
  - Any slot differing from the result pulses fault on the cycle valid_o rises.
- OUTPUT:
  - ready_o=0; valid_o and data_o are held stable until ready_i.
  - On handshake: last_id<=cur_id, cnt<=0, lock_o<=0, back to COLLECT in the same cycle edge. The next copy can be accepted on the following cycle.
- Lock timeout:
  - A counter resets on every accept and increments each cycle while COLLECT and cnt>0.
  - At LockTimeout, lock_o<=0 and the counter saturates. The partial group is retained and collection continues.
  - lock_o re-asserts on the next accepted copy of the same group.
- Simultaneous events: the fault pulse and a group restart occur in the same cycle. Pulses from multiple causes in one cycle merge into a single 1-cycle pulse.
- ID wrap-around: IDs compare for equality only, so a wrap from 2^IDSize-1 to 0 is legal.

Test Plan:
- Bypass: enable_i=0, data 0xA5 id 3, ready_i=1 -> data_o=0xA5 and valid_o=1 in the same cycle; lock_o=0.
- Clean TMR: three copies 0x3C id 7 on consecutive cycles -> valid_o=1 one cycle after the third, data_o=0x3C, no fault; lock_o high from the cycle after the first copy until the handshake.
- Data fault: copies 0x3C, 0x7C, 0x3C id 2 -> data_o=0x3C, fault pulse once. With Redundancy=5 and copies 1,2,3,4,5 (no majority) -> data_o=bitwise majority=0x01, fault pulse.
- ID fault: copies id 4, id 9, then three copies id 9 -> fault on the second accept, one output of the id-9 data; then an extra id-9 copy -> dropped with a fault pulse, no output.
- Timeout: one copy accepted then valid_i=0 for 6 cycles, LockTimeout=5 -> lock_o falls after 5 idle cycles; the remaining two copies still produce a correct output.
- Backpressure and reset: ready_i=0 for 10 cycles in OUTPUT -> data_o stable, ready_o=0; rst_i pulsed mid-group -> all outputs 0 and the next full group is voted correctly.

Source files
------------

// File: rtl/time_nmr_end.sv
// N-modular time-redundant end stage: collects Redundancy tagged copies,
// majority-votes them word-wise and emits one result per group.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   enable_i             1 = redundancy mode, 0 = combinational bypass
//   data_i, id_i         incoming copy payload and group ID
//   valid_i, ready_o     upstream handshake
//   data_o, valid_o      voted result towards the consumer
//   ready_i              downstream ready
//   lock_o               holds the upstream arbiter while a group is open
//   fault_detected_o     one-cycle pulse on any detected discrepancy
module time_nmr_end #(
    parameter int DataWidth   = 8,
    parameter int IDSize      = 5,
    parameter int Redundancy  = 3,
    parameter int LockTimeout = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [IDSize-1:0]    id_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 lock_o,
    output logic                 fault_detected_o
);

    localparam int CW = $clog2(Redundancy + 1);
    localparam int TW = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    state_e                                 state_q, state_d;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [Redundancy-1:0][DataWidth-1:0]   slot_q, slot_d;
    logic [IDSize-1:0]                      cur_id_q, cur_id_d;
    logic [IDSize-1:0]                      last_id_q, last_id_d;
    logic                                   lock_q, lock_d;
    logic [DataWidth-1:0]                   data_q, data_d;
    logic                                   fault_q, fault_d;
    logic [TW-1:0]                          tmo_q, tmo_d;

    logic bypass;
    logic accept;

    // Word majority first (lowest index wins); bitwise majority otherwise.
    function automatic logic [DataWidth-1:0] vote_fn(
        input logic [Redundancy-1:0][DataWidth-1:0] s
    );
        logic [DataWidth-1:0] res;
        logic                 found;
        int                   m;
        int                   ones;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < Redundancy; i++) begin
            m = 0;
            for (int j = 0; j < Redundancy; j++) begin
                if (s[j] == s[i]) m++;
            end
            if (!found && m >= Redundancy / 2 + 1) begin
                res   = s[i];
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int b = 0; b < DataWidth; b++) begin
                ones = 0;
                for (int j = 0; j < Redundancy; j++) begin
                    if (s[j][b]) ones++;
                end
                res[b] = (ones > Redundancy / 2);
            end
        end
        return res;
    endfunction

    // enable_i only matters between groups.
    assign bypass = (state_q == COLLECT) && (cnt_q == '0) && !enable_i;
    assign accept = !bypass && (state_q == COLLECT) && valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            slot_q    <= '0;
            cur_id_q  <= '0;
            last_id_q <= '1;
            lock_q    <= 1'b0;
            data_q    <= '0;
            fault_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            lock_q    <= lock_d;
            data_q    <= data_d;
            fault_q   <= fault_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        lock_d    = lock_q;
        data_d    = data_q;
        fault_d   = 1'b0;
        tmo_d     = tmo_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    tmo_d = '0;
                    if (cnt_q == '0 && id_i == last_id_q) begin
                        // Stale or surplus copy of the group just emitted.
                        fault_d = 1'b1;
                    end else if (cnt_q != '0 && id_i == cur_id_q) begin
                        slot_d[cnt_q] = data_i;
                        cnt_d         = cnt_q + CW'(1);
                        lock_d        = 1'b1;
                    end else begin
                        // New group, or a foreign ID aborting the open one.
                        fault_d   = (cnt_q != '0);
                        slot_d[0] = data_i;
                        cur_id_d  = id_i;
                        cnt_d     = CW'(1);
                        lock_d    = 1'b1;
                    end
                    if (cnt_d == CW'(Redundancy)) begin
                        state_d = OUTPUT;
                        data_d  = vote_fn(slot_d);
                        for (int i = 0; i < Redundancy; i++) begin
                            if (slot_d[i] != data_d) fault_d = 1'b1;
                        end
                    end
                end else if (cnt_q != '0) begin
                    // Idle inside a group: release the arbiter after a while.
                    if (LockTimeout != 0 && tmo_q != TW'(LockTimeout)) begin
                        tmo_d = tmo_q + TW'(1);
                        if (tmo_d == TW'(LockTimeout)) lock_d = 1'b0;
                    end
                end
            end
            OUTPUT: begin
                if (ready_i) begin
                    state_d   = COLLECT;
                    cnt_d     = '0;
                    lock_d    = 1'b0;
                    last_id_d = cur_id_q;
                    tmo_d     = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (bypass) begin
            data_o  = data_i;
            valid_o = valid_i;
            ready_o = ready_i;
            lock_o  = 1'b0;
        end else begin
            data_o  = data_q;
            valid_o = (state_q == OUTPUT);
            ready_o = (state_q == COLLECT);
            lock_o  = lock_q;
        end
    end

    assign fault_detected_o = fault_q;

endmodule

// File: tb/tb_time_nmr_end.sv
// Testbench for time_nmr_end: scoreboard on the Redundancy=3 instance,
// inline checks on a Redundancy=5 instance.
module tb_time_nmr_end;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b1;
    logic [7:0] data_i = '0;
    logic [4:0] id_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic       lock_o;
    logic       fault_o;

    logic       en5 = 1'b1;
    logic [7:0] d5 = '0;
    logic [4:0] id5 = '0;
    logic       v5 = 1'b0;
    logic       rdy5_o;
    logic [7:0] q5;
    logic       val5_o;
    logic       rdy5 = 1'b1;
    logic       lock5;
    logic       fault5;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    time_nmr_end #(
        .DataWidth(8), .IDSize(5), .Redundancy(3), .LockTimeout(5)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .data_i(data_i), .id_i(id_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .lock_o(lock_o),
        .fault_detected_o(fault_o)
    );

    time_nmr_end #(
        .DataWidth(8), .IDSize(5), .Redundancy(5), .LockTimeout(5)
    ) u_dut5 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(en5),
        .data_i(d5), .id_i(id5), .valid_i(v5),
        .ready_o(rdy5_o), .data_o(q5), .valid_o(val5_o),
        .ready_i(rdy5), .lock_o(lock5),
        .fault_detected_o(fault5)
    );

    // Scoreboard: every output handshake pops one expected word.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no output",
                         data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h, required %h", data_o, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one copy and return 1ns after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic [4:0] id);
        int n;
        n = 0;
        data_i  = d;
        id_i    = id;
        valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready_o %b, required 1", ready_o);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({valid_o, data_o, lock_o, fault_o, ready_o} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: v=%b d=%h l=%b f=%b r=%b, required 0 00 0 0 1",
                     valid_o, data_o, lock_o, fault_o, ready_o);
        end
        n_tests++;
        if ({val5_o, q5, lock5, fault5} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_state5: v=%b d=%h l=%b f=%b, required zeros",
                     val5_o, q5, lock5, fault5);
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        enable_i = 1'b0;
        ready_i  = 1'b1;
        data_i   = 8'hA5;
        id_i     = 5'd3;
        valid_i  = 1'b1;
        exp_q.push_back(8'hA5);
        #1;
        n_tests++;
        if ({data_o, valid_o, lock_o, ready_o} !== {8'hA5, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass: d=%h v=%b l=%b r=%b, required a5 1 0 1",
                     data_o, valid_o, lock_o, ready_o);
        end
        @(posedge clk_i);
        #1;
        valid_i  = 1'b0;
        enable_i = 1'b1;
        tick();
    endtask

    task automatic test_clean_tmr();
        exp_q.push_back(8'h3C);
        send(8'h3C, 5'd7);
        n_tests++;
        if (lock_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_lock1: lock %b, required 1", lock_o);
        end
        send(8'h3C, 5'd7);
        send(8'h3C, 5'd7);
        n_tests++;
        if ({valid_o, data_o, fault_o, lock_o} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clean_out: v=%b d=%h f=%b l=%b, required 1 3c 0 1",
                     valid_o, data_o, fault_o, lock_o);
        end
        tick();
        n_tests++;
        if ({valid_o, lock_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL clean_release: v=%b l=%b, required 0 0",
                     valid_o, lock_o);
        end
    endtask

    task automatic test_data_fault();
        exp_q.push_back(8'h3C);
        send(8'h3C, 5'd2);
        send(8'h7C, 5'd2);
        send(8'h3C, 5'd2);
        n_tests++;
        if ({valid_o, data_o, fault_o} !== {1'b1, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL data_fault: v=%b d=%h f=%b, required 1 3c 1",
                     valid_o, data_o, fault_o);
        end
        tick();
        n_tests++;
        if (fault_o !== 1'b0) begin
            n_fail++;
            $display("FAIL data_fault_pulse: fault %b, required 0", fault_o);
        end
    endtask

    task automatic test_nmr5();
        logic [7:0] w1[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [7:0] w2[5] = '{8'hC3, 8'h0F, 8'hC3, 8'hF0, 8'hC3};
        foreach (w1[i]) begin
            d5 = w1[i]; id5 = 5'd1; v5 = 1'b1;
            tick();
        end
        v5 = 1'b0;
        n_tests++;
        if ({val5_o, q5, fault5} !== {1'b1, 8'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL nmr5_bitwise: v=%b d=%h f=%b, required 1 01 1",
                     val5_o, q5, fault5);
        end
        tick();
        foreach (w2[i]) begin
            d5 = w2[i]; id5 = 5'd2; v5 = 1'b1;
            tick();
        end
        v5 = 1'b0;
        n_tests++;
        if ({val5_o, q5, fault5} !== {1'b1, 8'hC3, 1'b1}) begin
            n_fail++;
            $display("FAIL nmr5_word: v=%b d=%h f=%b, required 1 c3 1",
                     val5_o, q5, fault5);
        end
        tick();
    endtask

    task automatic test_id_fault();
        send(8'h11, 5'd4);
        n_tests++;
        if (fault_o !== 1'b0) begin
            n_fail++;
            $display("FAIL id_first: fault %b, required 0", fault_o);
        end
        exp_q.push_back(8'h55);
        send(8'h55, 5'd9);
        n_tests++;
        if ({fault_o, lock_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL id_mismatch: f=%b l=%b, required 1 1",
                     fault_o, lock_o);
        end
        send(8'h55, 5'd9);
        send(8'h55, 5'd9);
        n_tests++;
        if ({valid_o, data_o, fault_o} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL id_out: v=%b d=%h f=%b, required 1 55 0",
                     valid_o, data_o, fault_o);
        end
        send(8'h66, 5'd9);
        n_tests++;
        if ({fault_o, valid_o, lock_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL id_stale: f=%b v=%b l=%b, required 1 0 0",
                     fault_o, valid_o, lock_o);
        end
        repeat (3) begin
            tick();
            n_tests++;
            if ({valid_o, fault_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL id_stale_quiet: v=%b f=%b, required 0 0",
                         valid_o, fault_o);
            end
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back(8'h5A);
        send(8'h5A, 5'd12);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (lock_o !== (k < 5)) begin
                n_fail++;
                $display("FAIL timeout_lock_%0d: lock %b, required %b",
                         k, lock_o, (k < 5));
            end
        end
        send(8'h5A, 5'd12);
        n_tests++;
        if (lock_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_relock: lock %b, required 1", lock_o);
        end
        send(8'h5A, 5'd12);
        n_tests++;
        if ({valid_o, data_o} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL timeout_out: v=%b d=%h, required 1 5a",
                     valid_o, data_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        exp_q.push_back(8'h99);
        send(8'h99, 5'd20);
        send(8'h99, 5'd20);
        send(8'h99, 5'd20);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if ({valid_o, data_o, ready_o, lock_o} !== {1'b1, 8'h99, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: v=%b d=%h r=%b l=%b, required 1 99 0 1",
                         k, valid_o, data_o, ready_o, lock_o);
            end
            tick();
        end
        ready_i = 1'b1;
        tick();
        n_tests++;
        if ({valid_o, ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: v=%b r=%b, required 0 1",
                     valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid_group();
        send(8'h10, 5'd21);
        rst_i = 1'b1;
        #1;
        n_tests++;
        if ({valid_o, data_o, lock_o, fault_o} !== 11'h0) begin
            n_fail++;
            $display("FAIL rst_mid: v=%b d=%h l=%b f=%b, required zeros",
                     valid_o, data_o, lock_o, fault_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        exp_q.push_back(8'h42);
        send(8'h42, 5'd21);
        send(8'h42, 5'd21);
        send(8'h42, 5'd21);
        n_tests++;
        if ({valid_o, data_o, fault_o} !== {1'b1, 8'h42, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_regroup: v=%b d=%h f=%b, required 1 42 0",
                     valid_o, data_o, fault_o);
        end
        tick();
        tick();
    endtask

    task automatic test_drain();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d outputs missing, required 0",
                     exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_clean_tmr();
        test_data_fault();
        test_nmr5();
        test_id_fault();
        test_timeout();
        test_backpressure();
        test_reset_mid_group();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
